// File: rtl/run_ctrl_monitor.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module  : run_ctrl_monitor                                              |
// | Counts cycles/retires/events, halts the core at a retire limit, then    |
// | streams a PC snapshot and the register file over valid/ready.           |
// | Option  : RCM_DUMP_CHECKSUM_EN appends an XOR checksum beat.            |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module run_ctrl_monitor #(
  parameter int CNT_W     = 32,
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter int NUM_EVT   = 4,
  parameter int DRAIN_CYC = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic [CNT_W-1:0]         run_limit_i,
  input  logic                     retire_i,
  input  logic [NUM_EVT-1:0]       evt_i,
  input  logic [XLEN-1:0]          pc_i,
  output logic                     halt_o,
  output logic [$clog2(NREGS)-1:0] rf_raddr_o,
  input  logic [XLEN-1:0]          rf_rdata_i,
  output logic                     dump_valid_o,
  input  logic                     dump_ready_i,
  output logic [$clog2(NREGS)+1:0] dump_idx_o,
  output logic [XLEN-1:0]          dump_data_o,
  output logic                     done_o,
  output logic [CNT_W-1:0]         cycle_cnt_o,
  output logic [CNT_W-1:0]         instret_o,
  output logic [NUM_EVT*CNT_W-1:0] evt_cnt_o
);

  localparam int c_aw = $clog2(NREGS);
  localparam int c_iw = c_aw + 2;
  localparam int c_dw = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
  localparam logic [c_iw-1:0]  c_idx_one  = c_iw'(1);
  localparam logic [c_dw-1:0]  c_drn_one  = c_dw'(1);
  localparam logic [c_dw-1:0]  c_drn_last = c_dw'(DRAIN_CYC - 1);
`ifdef RCM_DUMP_CHECKSUM_EN
  localparam logic [c_iw-1:0]  c_last_idx = c_iw'(NREGS + 1);
`else
  localparam logic [c_iw-1:0]  c_last_idx = c_iw'(NREGS);
`endif

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DUMP  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  limit_q;
  logic [CNT_W-1:0]  cyc_q;
  logic [CNT_W-1:0]  inst_q;
  logic [CNT_W-1:0]  evt_q [NUM_EVT];
  logic [XLEN-1:0]   pc_snap_q;
  logic [c_dw-1:0]   drain_q;
  logic [c_iw-1:0]   idx_q;
  logic [c_aw-1:0]   raddr_q;
  logic              valid_q;
  logic              halt_q;
  logic              done_q;
`ifdef RCM_DUMP_CHECKSUM_EN
  logic [XLEN-1:0]   csum_q;
`endif
  logic [XLEN-1:0]   w_beat_data;
  logic              w_limit_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + c_cnt_one;
  endfunction

  // A saturated instret wraps to zero here, which never equals a nonzero limit.
  assign w_limit_hit = (limit_q != '0) && retire_i && ((inst_q + c_cnt_one) == limit_q);

  always_comb begin
    w_beat_data = rf_rdata_i;
    if (idx_q == '0) w_beat_data = pc_snap_q;
`ifdef RCM_DUMP_CHECKSUM_EN
    else if (idx_q == c_last_idx) w_beat_data = csum_q;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      limit_q   <= '0;
      cyc_q     <= '0;
      inst_q    <= '0;
      for (int i = 0; i < NUM_EVT; i++) evt_q[i] <= '0;
      pc_snap_q <= '0;
      drain_q   <= '0;
      idx_q     <= '0;
      raddr_q   <= '0;
      valid_q   <= 1'b0;
      halt_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef RCM_DUMP_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      // Counters run through DRAIN so in-flight retires are still accounted for.
      if (state_q == ST_RUN || state_q == ST_DRAIN) begin
        cyc_q <= sat_inc(cyc_q);
        if (retire_i) inst_q <= sat_inc(inst_q);
        for (int i = 0; i < NUM_EVT; i++) begin
          if (evt_i[i]) evt_q[i] <= sat_inc(evt_q[i]);
        end
      end

      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            cyc_q   <= '0;
            inst_q  <= '0;
            for (int i = 0; i < NUM_EVT; i++) evt_q[i] <= '0;
            limit_q <= run_limit_i;
            halt_q  <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= '0;
            raddr_q <= '0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_limit_hit) begin
            pc_snap_q <= pc_i;
            drain_q   <= '0;
            halt_q    <= 1'b1;
            state_q   <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drain_q == c_drn_last) begin
            idx_q   <= '0;
            raddr_q <= '0;
            valid_q <= 1'b1;
`ifdef RCM_DUMP_CHECKSUM_EN
            csum_q  <= '0;
`endif
            state_q <= ST_DUMP;
          end else begin
            drain_q <= drain_q + c_drn_one;
          end
        end
        ST_DUMP: begin
          if (valid_q && dump_ready_i) begin
`ifdef RCM_DUMP_CHECKSUM_EN
            csum_q <= csum_q ^ w_beat_data;
`endif
            if (idx_q == c_last_idx) begin
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              // Beat k+1 reads register k.
              raddr_q <= c_aw'(idx_q);
              idx_q   <= idx_q + c_idx_one;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign halt_o       = halt_q;
  assign done_o       = done_q;
  assign dump_valid_o = valid_q;
  assign dump_idx_o   = idx_q;
  assign rf_raddr_o   = raddr_q;
  assign dump_data_o  = valid_q ? w_beat_data : '0;
  assign cycle_cnt_o  = cyc_q;
  assign instret_o    = inst_q;

  generate
    for (genvar gi = 0; gi < NUM_EVT; gi++) begin : g_evt_out
      assign evt_cnt_o[gi*CNT_W +: CNT_W] = evt_q[gi];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_run_ctrl_monitor.sv
`default_nettype none
// Testbench for run_ctrl_monitor: scenario table with randomized stimulus
// against a counting model, plus hand sequences for saturation/unlimited/reset.
module tb_run_ctrl_monitor;

  localparam int D  = 4;
  localparam int NR = 32;
`ifdef RCM_DUMP_CHECKSUM_EN
  localparam int NB = NR + 2;
`else
  localparam int NB = NR + 1;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start_i, retire_i, dump_ready_i;
  logic [31:0]  run_limit_i, pc_i, rf_rdata_i;
  logic [3:0]   evt_i;
  logic         halt_o, dump_valid_o, done_o;
  logic [4:0]   rf_raddr_o;
  logic [6:0]   dump_idx_o;
  logic [31:0]  dump_data_o, cycle_cnt_o, instret_o;
  logic [127:0] evt_cnt_o;
  logic [31:0]  rf_mem [NR];

  // narrow-counter instance for saturation checks
  logic         s_start, s_retire, s_halt, s_valid, s_done;
  logic [3:0]   s_evt, s_cyc, s_inst;
  logic [4:0]   s_raddr;
  logic [6:0]   s_idx;
  logic [31:0]  s_data;
  logic [15:0]  s_evtc;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;
  assign rf_rdata_i = rf_mem[rf_raddr_o];

  run_ctrl_monitor #(.CNT_W(32), .XLEN(32), .NREGS(NR), .NUM_EVT(4), .DRAIN_CYC(D)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .run_limit_i(run_limit_i),
    .retire_i(retire_i), .evt_i(evt_i), .pc_i(pc_i), .halt_o(halt_o),
    .rf_raddr_o(rf_raddr_o), .rf_rdata_i(rf_rdata_i), .dump_valid_o(dump_valid_o),
    .dump_ready_i(dump_ready_i), .dump_idx_o(dump_idx_o), .dump_data_o(dump_data_o),
    .done_o(done_o), .cycle_cnt_o(cycle_cnt_o), .instret_o(instret_o), .evt_cnt_o(evt_cnt_o)
  );

  run_ctrl_monitor #(.CNT_W(4), .XLEN(32), .NREGS(NR), .NUM_EVT(4), .DRAIN_CYC(D)) dut_s (
    .clk(clk), .rst(rst), .start_i(s_start), .run_limit_i(4'h0),
    .retire_i(s_retire), .evt_i(s_evt), .pc_i(32'h0), .halt_o(s_halt),
    .rf_raddr_o(s_raddr), .rf_rdata_i(32'h0), .dump_valid_o(s_valid),
    .dump_ready_i(1'b1), .dump_idx_o(s_idx), .dump_data_o(s_data),
    .done_o(s_done), .cycle_cnt_o(s_cyc), .instret_o(s_inst), .evt_cnt_o(s_evtc)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // limit, retire %, ready mode (0 always, 1 pattern 1,0,0, 2 random),
  // rf mode (0 index values + PC 0x100, 1 random), expected instret/cycles (-1 = model only)
  typedef struct {
    logic [31:0] limit;
    int          retire_pct;
    int          ready_mode;
    int          rf_mode;
    int          exp_inst;
    int          exp_cyc;
  } scen_t;

  scen_t tbl [5];

  task automatic run_scenario(input scen_t s);
    int          retired, cyc, drain_left, b;
    bit          halted;
    logic [31:0] ev [4];
    logic [31:0] pc_snap;
    logic [31:0] beats [NB];
    logic [127:0] exp_evt;

    for (int i = 0; i < NR; i++) rf_mem[i] = (s.rf_mode == 0) ? 32'(i) : $urandom;
    start_i = 1'b1; run_limit_i = s.limit; retire_i = 1'b0; evt_i = '0; dump_ready_i = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b0;
    chk("start_instret", instret_o, 0);
    chk("start_cycles", cycle_cnt_o, 0);
    chk("start_done", done_o, 0);
    chk("start_halt", halt_o, 0);

    retired = 0; cyc = 0; halted = 1'b0; drain_left = D; pc_snap = '0;
    for (int i = 0; i < 4; i++) ev[i] = '0;
    for (int k = 0; k < 3000 && drain_left > 0; k++) begin
      retire_i    = ($urandom_range(99) < s.retire_pct);
      evt_i       = 4'($urandom);
      pc_i        = (s.rf_mode == 0) ? 32'h100 : $urandom;
      start_i     = ($urandom_range(9) == 0);
      run_limit_i = $urandom;
      @(posedge clk); #1;
      cyc++;
      if (retire_i) retired++;
      for (int i = 0; i < 4; i++) if (evt_i[i]) ev[i]++;
      if (halted) drain_left--;
      else if (retire_i && retired == int'(s.limit)) begin
        halted  = 1'b1;
        pc_snap = pc_i;
      end
      chk("run_halt", halt_o, halted);
      chk("run_valid", dump_valid_o, (drain_left == 0));
    end
    chk("drain_timeout", drain_left, 0);
    chk("instret", instret_o, retired);
    chk("cycles", cycle_cnt_o, cyc);
    if (s.exp_inst >= 0) chk("instret_tbl", instret_o, s.exp_inst);
    if (s.exp_cyc >= 0)  chk("cycles_tbl", cycle_cnt_o, s.exp_cyc);
    exp_evt = '0;
    for (int i = 0; i < 4; i++) exp_evt[i*32 +: 32] = ev[i];
    chk("evt_cnt", evt_cnt_o, exp_evt);

    beats[0] = pc_snap;
    for (int i = 0; i < NR; i++) beats[i+1] = rf_mem[i];
`ifdef RCM_DUMP_CHECKSUM_EN
    beats[NB-1] = '0;
    for (int i = 0; i < NB - 1; i++) beats[NB-1] ^= beats[i];
`endif

    b = 0;
    for (int k = 0; k < 2000 && b < NB; k++) begin
      chk("dump_valid", dump_valid_o, 1);
      chk("dump_idx", dump_idx_o, b);
      chk("dump_data", dump_data_o, beats[b]);
      chk("dump_halt", halt_o, 1);
      chk("dump_frozen", instret_o, retired);
      case (s.ready_mode)
        0:       dump_ready_i = 1'b1;
        1:       dump_ready_i = (k % 3 == 0);
        default: dump_ready_i = 1'($urandom_range(1));
      endcase
      retire_i = 1'($urandom); evt_i = 4'($urandom); start_i = ($urandom_range(9) == 0);
      @(posedge clk); #1;
      if (dump_ready_i) b++;
    end
    chk("dump_beats", b, NB);
    dump_ready_i = 1'b0; start_i = 1'b0; retire_i = 1'b0; evt_i = '0;
    chk("end_valid", dump_valid_o, 0);
    chk("end_done", done_o, 1);
    chk("end_halt", halt_o, 1);
    chk("end_cycles", cycle_cnt_o, cyc);
    chk("end_evt", evt_cnt_o, exp_evt);
    @(posedge clk); #1;
    chk("done_hold", done_o, 1);
  endtask

  initial begin
    bit ever_halt;
    tbl[0] = '{32'd80, 100, 0, 0, 84, 84};
    tbl[1] = '{32'd40, 100, 1, 0, 44, 44};
    tbl[2] = '{32'd25,  60, 2, 1, -1, -1};
    tbl[3] = '{32'd1,  100, 2, 1,  5,  5};
    tbl[4] = '{32'd50,  30, 1, 1, -1, -1};

    rst = 1'b0; start_i = 1'b0; retire_i = 1'b0; evt_i = '0; pc_i = '0;
    run_limit_i = '0; dump_ready_i = 1'b0;
    s_start = 1'b0; s_retire = 1'b0; s_evt = '0;
    for (int i = 0; i < NR; i++) rf_mem[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_halt", halt_o, 0);
    chk("rst_valid", dump_valid_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_idx", dump_idx_o, 0);
    chk("rst_raddr", rf_raddr_o, 0);
    chk("rst_data", dump_data_o, 0);
    chk("rst_counters", {cycle_cnt_o, instret_o}, 0);
    chk("rst_evt", evt_cnt_o, 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // narrow counters saturate at 0xF
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0; s_evt = 4'b0100; s_retire = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    s_evt = '0; s_retire = 1'b0;
    chk("sat_evt", s_evtc, 16'h0F00);
    chk("sat_inst", s_inst, 4'hF);
    chk("sat_cyc", s_cyc, 4'hF);
    chk("sat_halt", s_halt, 0);

    for (int t = 0; t < 5; t++) run_scenario(tbl[t]);

    // unlimited run from DONE
    start_i = 1'b1; run_limit_i = '0;
    @(posedge clk); #1;
    start_i = 1'b0; retire_i = 1'b1; ever_halt = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(posedge clk); #1;
      if (halt_o) ever_halt = 1'b1;
    end
    retire_i = 1'b0;
    chk("unlim_halt", ever_halt, 0);
    chk("unlim_instret", instret_o, 1000);
    chk("unlim_cycles", cycle_cnt_o, 1000);
    chk("unlim_done", done_o, 0);

    // asynchronous reset at beat 10
    rst = 1'b0; #2; rst = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b1; run_limit_i = 32'd5; retire_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; dump_ready_i = 1'b1;
    for (int k = 0; k < 200 && !(dump_valid_o && dump_idx_o == 7'd10); k++) begin
      @(posedge clk); #1;
    end
    chk("rst_wait_idx", dump_idx_o, 10);
    #2; rst = 1'b0; #1;
    chk("arst_valid", dump_valid_o, 0);
    chk("arst_halt", halt_o, 0);
    chk("arst_counters", {cycle_cnt_o, instret_o}, 0);
    chk("arst_evt", evt_cnt_o, 0);
    chk("arst_data", dump_data_o, 0);
    @(negedge clk); rst = 1'b1; retire_i = 1'b0; dump_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_valid", dump_valid_o, 0);
    chk("post_rst_halt", halt_o, 0);
    run_scenario(tbl[1]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
